ac_feed_ctrl: RTL and testbench
===============================

AC_FEED_CTRL -- requirements
Module: ac_feed_ctrl

Interface
REQ-001 Parameter DEPTH, default 32, number of text-buffer entries (power of two).
REQ-002 Parameter W, default 8, character width.
REQ-003 CLK  in  1  the block's single clock; all state changes on its rising edge.
REQ-004 RST  in  1  reset, asynchronous and active-low.
REQ-005 WR_EN  in  1  host writes WR_DATA into the text buffer.
REQ-006 WR_DATA  in  W  character to store.
REQ-007 CLR  in  1  clear the buffer write count (honoured in IDLE only).
REQ-008 LEN  in  log2(DEPTH)+1  number of characters to scan, 1..DEPTH.
REQ-009 START  in  1  begin a scan of buffer entries 0..LEN-1.
REQ-010 ABORT  in  1  terminate a scan in progress.
REQ-011 MATCH  in  1  match flag from the Aho-Corasick engine, valid one cycle after its character.
REQ-012 EN  out  1  engine load strobe (first character, root transition).
REQ-013 EN_A  out  1  engine advance strobe (subsequent characters).
REQ-014 STRING  out  W  character presented to the engine.
REQ-015 FULL  out  1  buffer holds DEPTH characters.
REQ-016 BUSY  out  1  scan in progress.
REQ-017 DONE  out  1  one-cycle pulse at scan completion.
REQ-018 MATCH_CNT  out  log2(DEPTH)+1  matches counted in the last scan.
REQ-019 POS  out  log2(DEPTH)  buffer index of the most recent matching character.

Function
REQ-020 All outputs SHALL be registered; EN, EN_A, STRING, DONE SHALL be 0 outside the states that drive them.
REQ-021 FSM states SHALL be IDLE, LOAD, RUN, FLUSH, DONE; BUSY=1 in every state except IDLE.
REQ-022 In IDLE, WR_EN with FULL=0 SHALL store WR_DATA at index wr_cnt and increment wr_cnt; WR_EN with FULL=1 or outside IDLE SHALL be ignored.
REQ-023 CLR in IDLE SHALL set wr_cnt to 0; CLR and WR_EN together SHALL clear and store nothing.
REQ-024 START in IDLE with 1<=LEN<=wr_cnt SHALL enter LOAD next cycle, clear MATCH_CNT and POS; otherwise START SHALL be ignored.
REQ-025 LOAD lasts one cycle: EN=1, EN_A=0, STRING=buf[0].
REQ-026 RUN lasts LEN-1 cycles: EN_A=1, STRING=buf[k] for k=1..LEN-1; LEN=1 SHALL go LOAD->FLUSH.
REQ-027 FLUSH lasts one cycle with EN=EN_A=0 to collect the last character's MATCH.
REQ-028 MATCH sampled in RUN or FLUSH SHALL increment MATCH_CNT (saturating at DEPTH) and load POS with the index of the previous character presented.
REQ-029 DONE state lasts one cycle with DONE=1, then IDLE; buffer contents and wr_cnt SHALL be preserved.
REQ-030 START latency: START sampled at cycle t gives EN=1 at t+1, DONE=1 at t+LEN+2.
REQ-031 ABORT in LOAD, RUN or FLUSH SHALL go to IDLE next cycle without DONE; MATCH_CNT/POS keep partial values; ABORT has priority over all other transitions.
REQ-032 START, WR_EN, CLR received outside IDLE SHALL be ignored.

Reset
REQ-033 RST low SHALL immediately force IDLE, wr_cnt=0, all outputs 0; buffer contents need not be reset.
REQ-034 RST asserted mid-scan SHALL abandon the scan with no DONE pulse.

Structure
REQ-035 Shared package SHALL hold DEPTH, W defaults and the state encoding enum.
REQ-036 Text buffer SHALL be a sub-module ac_text_buf (DEPTH x W, one write port, one asynchronous read port).

Verification
REQ-037 Write 'a','b','c' (61,62,63), START LEN=3 -> EN=1 STRING=61 at t+1; EN_A=1 STRING=62,63 at t+2,t+3; DONE at t+5.
REQ-038 MATCH pulsed at t+3 and t+4 with LEN=3 -> MATCH_CNT=2, POS=2 at DONE.
REQ-039 LEN=1 -> LOAD, FLUSH, DONE; DONE at t+3, EN_A never asserted.
REQ-040 START with LEN=4, wr_cnt=3, and with LEN=0 -> no BUSY, outputs stay 0.
REQ-041 Write 33 characters -> FULL=1 after 32nd, 33rd ignored; CLR -> FULL=0, wr_cnt=0.
REQ-042 ABORT at t+2 of LEN=5 scan, and RST low at t+2 in a repeat -> IDLE at t+3 / immediately, no DONE, EN_A=0.

Source files
------------

// File: rtl/ac_feed_ctrl_pkg.sv
// Shared defaults and FSM encoding for the Aho-Corasick text feeder.
package ac_feed_ctrl_pkg;

  localparam int unsigned DefDepth = 32;
  localparam int unsigned DefW     = 8;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StRun   = 3'd2,
    StFlush = 3'd3,
    StDone  = 3'd4
  } state_e;

endpackage

// File: rtl/ac_text_buf.sv
// Text buffer: DEPTH x W storage, one synchronous write port, one asynchronous read port.
module ac_text_buf
  import ac_feed_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned W     = DefW
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ac_feed_ctrl.sv
// Feeds buffered text to an Aho-Corasick engine one character per cycle and counts matches.
module ac_feed_ctrl
  import ac_feed_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned W     = DefW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     clr,
  input  logic [$clog2(DEPTH):0]   len,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     match,
  output logic                     en,
  output logic                     en_a,
  output logic [W-1:0]             string_char,
  output logic                     full,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   match_cnt,
  output logic [$clog2(DEPTH)-1:0] pos
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] cnt_d;
  logic [AW-1:0] pos_d;
  logic          we;
  logic [W-1:0]  rd_data;

  ac_text_buf #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_text_buf (
    .clk   (clk),
    .we    (we),
    .waddr (wr_cnt_q[AW-1:0]),
    .wdata (wr_data),
    .raddr (idx_d),
    .rdata (rd_data)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    wr_cnt_d = wr_cnt_q;
    cnt_d    = match_cnt;
    pos_d    = pos;
    we       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (clr) begin
          wr_cnt_d = '0;
        end else if (wr_en && !full) begin
          we       = 1'b1;
          wr_cnt_d = wr_cnt_q + CW'(1);
        end
        if (start && (len != '0) && (len <= wr_cnt_q)) begin
          state_d = StLoad;
          idx_d   = '0;
          len_d   = len;
          cnt_d   = '0;
          pos_d   = '0;
        end
      end
      StLoad: begin
        if (len_q == CW'(1)) begin
          state_d = StFlush;
        end else begin
          state_d = StRun;
          idx_d   = idx_q + AW'(1);
        end
      end
      StRun: begin
        if ({1'b0, idx_q} == len_q - CW'(1)) begin
          state_d = StFlush;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      StFlush: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Engine MATCH lags its character by one cycle, so it refers to the previous index.
    if (match && (state_q inside {StRun, StFlush})) begin
      if (match_cnt != CW'(DEPTH)) begin
        cnt_d = match_cnt + CW'(1);
      end
      pos_d = (state_q == StRun) ? idx_q - AW'(1) : idx_q;
    end

    if (abort && (state_q inside {StLoad, StRun, StFlush})) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      len_q       <= '0;
      wr_cnt_q    <= '0;
      full        <= 1'b0;
      match_cnt   <= '0;
      pos         <= '0;
      en          <= 1'b0;
      en_a        <= 1'b0;
      string_char <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      wr_cnt_q    <= wr_cnt_d;
      full        <= (wr_cnt_d == CW'(DEPTH));
      match_cnt   <= cnt_d;
      pos         <= pos_d;
      en          <= (state_d == StLoad);
      en_a        <= (state_d == StRun);
      string_char <= (state_d inside {StLoad, StRun}) ? rd_data : '0;
      busy        <= (state_d != StIdle);
      done        <= (state_d == StDone);
    end
  end

endmodule

// File: tb/tb_ac_feed_ctrl.sv
// Directed bench for ac_feed_ctrl with a per-cycle expected-output scoreboard.
module tb_ac_feed_ctrl;

  localparam int DEPTH = 32;
  localparam int W     = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         clr = 1'b0;
  logic [5:0]   len_in = '0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         match = 1'b0;
  logic         en, en_a, full, busy, done;
  logic [W-1:0] string_char;
  logic [5:0]   match_cnt;
  logic [4:0]   pos;

  ac_feed_ctrl #(
    .DEPTH (DEPTH),
    .W     (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .clr         (clr),
    .len         (len_in),
    .start       (start),
    .abort       (abort),
    .match       (match),
    .en          (en),
    .en_a        (en_a),
    .string_char (string_char),
    .full        (full),
    .busy        (busy),
    .done        (done),
    .match_cnt   (match_cnt),
    .pos         (pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       en_a;
    logic [7:0] s;
    logic       done;
    logic       busy;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem_m [DEPTH];
  int         wr_cnt_m = 0;
  int         tests = 0;
  int         fails = 0;
  int         cnt_m;
  int         pos_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_char(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (wr_cnt_m < DEPTH) begin
      mem_m[wr_cnt_m] = d;
      wr_cnt_m++;
    end
  endtask

  task automatic idle_checks(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " en"}, 32'({en, en_a, done}), 32'd0);
      chk({tag, " str"}, 32'(string_char), 32'd0);
    end
  endtask

  // mpat[c] drives MATCH during cycle t+c; abort_c>0 asserts ABORT during cycle t+abort_c.
  task automatic scan(input int len, input logic [63:0] mpat, input int abort_c);
    int   last;
    exp_t e;
    last  = (abort_c > 0) ? abort_c + 1 : len + 3;
    cnt_m = 0;
    pos_m = 0;
    for (int c = 1; c <= last; c++) begin
      if (abort_c > 0 && c > abort_c) begin
        e = '{en: 1'b0, en_a: 1'b0, s: 8'h00, done: 1'b0, busy: 1'b0};
      end else begin
        e.en   = (c == 1);
        e.en_a = (c >= 2 && c <= len);
        e.s    = (c <= len) ? mem_m[c-1] : 8'h00;
        e.done = (c == len + 2);
        e.busy = (c <= len + 2);
      end
      sb.push_back(e);
    end
    for (int c = 2; c <= len + 1; c++) begin
      if ((abort_c == 0 || c <= abort_c) && mpat[c]) begin
        cnt_m++;
        pos_m = c - 2;
      end
    end

    len_in = 6'(len);
    start  = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (sb.size() == 0) begin
        chk($sformatf("scan%0d c%0d sb_empty", len, c), 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("scan%0d c%0d en", len, c), 32'(en), 32'(e.en));
        chk($sformatf("scan%0d c%0d en_a", len, c), 32'(en_a), 32'(e.en_a));
        chk($sformatf("scan%0d c%0d str", len, c), 32'(string_char), 32'(e.s));
        chk($sformatf("scan%0d c%0d done", len, c), 32'(done), 32'(e.done));
        chk($sformatf("scan%0d c%0d busy", len, c), 32'(busy), 32'(e.busy));
      end
      match = mpat[c];
      abort = (c == abort_c);
    end
    match = 1'b0;
    abort = 1'b0;
    chk($sformatf("scan%0d match_cnt", len), 32'(match_cnt), 32'(cnt_m));
    chk($sformatf("scan%0d pos", len), 32'(pos), 32'(pos_m));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst en", 32'(en), 32'd0);
    chk("rst en_a", 32'(en_a), 32'd0);
    chk("rst str", 32'(string_char), 32'd0);
    chk("rst full", 32'(full), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst match_cnt", 32'(match_cnt), 32'd0);
    chk("rst pos", 32'(pos), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    write_char(8'h61);
    write_char(8'h62);
    write_char(8'h63);
    chk("abc full", 32'(full), 32'd0);

    scan(3, (64'd1 << 3) | (64'd1 << 4), 0);
    scan(1, (64'd1 << 2), 0);
    scan(2, (64'd1 << 2) | (64'd1 << 3), 0);

    // Rejected starts: LEN beyond wr_cnt, and LEN of zero.
    len_in = 6'd4;
    start  = 1'b1;
    idle_checks("len4", 3);
    chk("len4 match_cnt kept", 32'(match_cnt), 32'(cnt_m));
    len_in = 6'd0;
    start  = 1'b1;
    idle_checks("len0", 3);

    write_char(8'h64);
    write_char(8'h65);
    scan(5, 64'd0, 2);
    idle_checks("post_abort", 3);

    // CLR together with WR_EN stores nothing.
    clr     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hee;
    @(negedge clk);
    clr      = 1'b0;
    wr_en    = 1'b0;
    wr_cnt_m = 0;
    len_in   = 6'd1;
    start    = 1'b1;
    idle_checks("clr_wr", 2);

    for (int i = 0; i < 33; i++) begin
      write_char(8'h40 + 8'(i));
      if (i == 30) chk("full after 31", 32'(full), 32'd0);
      if (i == 31) chk("full after 32", 32'(full), 32'd1);
      if (i == 32) chk("full after 33", 32'(full), 32'd1);
    end
    scan(32, (64'd1 << 10) | (64'd1 << 33), 0);

    clr = 1'b1;
    @(negedge clk);
    clr      = 1'b0;
    wr_cnt_m = 0;
    chk("clr full", 32'(full), 32'd0);
    len_in = 6'd1;
    start  = 1'b1;
    idle_checks("clr_start", 2);

    for (int i = 0; i < 5; i++) write_char(8'h70 + 8'(i));
    len_in = 6'd5;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rstscan c1 en", 32'(en), 32'd1);
    @(negedge clk);
    chk("rstscan c2 en_a", 32'(en_a), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstscan en", 32'({en, en_a}), 32'd0);
    chk("rstscan str", 32'(string_char), 32'd0);
    chk("rstscan busy", 32'(busy), 32'd0);
    chk("rstscan done", 32'(done), 32'd0);
    chk("rstscan cnt_pos", 32'({match_cnt, pos}), 32'd0);
    wr_cnt_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_checks("post_rst", 4);
    len_in = 6'd1;
    start  = 1'b1;
    idle_checks("rst_wrcnt", 2);

    chk("sb drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
